// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: enables one oscillator channel, lets it settle,
// then counts prescaled, synchronised oscillator edges over a window of clk cycles.
`timescale 1ns/1ps
module ring_osc_freq_meter #(
    parameter int NUM_CH = 12,
    parameter int CH_W   = 4,
    parameter int DIV_W  = 4,
    parameter int WIN_W  = 8,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [WIN_W-1:0]  win_cycles,
    input  logic [NUM_CH-1:0] osc_in,
    output logic [NUM_CH-1:0] osc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              err
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CYC_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [CH_W:0]      NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_t;

    state_t            state_q;
    logic [WIN_W-1:0]  win_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [NUM_CH-1:0] osc_en_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              err_q;

    logic [NUM_CH-1:0] pre_clr;
    logic [NUM_CH-1:0] pre_msb;
    logic [1:0]        sync_q;
    logic              sync_prev_q;
    logic              msb_any;
    logic              edge_det;

    // Disabled channels are held in clear, so OR-ing the MSBs yields the selected one.
    assign pre_clr = {NUM_CH{rst}} | ~osc_en_q;

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_pre
        logic [DIV_W-1:0] pre_q;
        always_ff @(posedge osc_in[gi] or posedge pre_clr[gi]) begin
            if (pre_clr[gi]) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + DIV_W'(1);
            end
        end
        assign pre_msb[gi] = pre_q[DIV_W-1];
    end

    assign msb_any  = |pre_msb;
    assign edge_det = sync_q[1] & ~sync_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], msb_any};
            sync_prev_q <= sync_q[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            cyc_q      <= '0;
            osc_en_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        win_q      <= win_cycles;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        err_q      <= 1'b0;
                        if ({1'b0, ch_sel} >= NUM_CH_L) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (win_cycles == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            osc_en_q <= NUM_CH'(1) << ch_sel;
                            busy_q   <= 1'b1;
                            cyc_q    <= CYC_W'(SETTLE);
                            state_q  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        osc_en_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (cyc_q == CYC_W'(1)) begin
                        cyc_q   <= CYC_W'(win_q);
                        state_q <= S_MEASURE;
                    end else begin
                        cyc_q <= cyc_q - CYC_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (abort) begin
                        osc_en_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        if (edge_det) begin
                            if (count_q == CNT_MAX) begin
                                overflow_q <= 1'b1;
                            end else begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
                        // The edge seen in the final window cycle is still counted above.
                        if (cyc_q == CYC_W'(1)) begin
                            osc_en_q <= '0;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            cyc_q <= cyc_q - CYC_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    osc_en_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign osc_en   = osc_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed plus randomized bench for ring_osc_freq_meter; expected counts come from
// oscillator period arithmetic with a bounded synchronisation tolerance.
`timescale 1ns/1ps
module tb_ring_osc_freq_meter;

    localparam int NUM_CH = 12;
    localparam int CH_W   = 4;
    localparam int DIV_W  = 2;
    localparam int WIN_W  = 8;
    localparam int CNT_W  = 4;
    localparam int SETTLE = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CH_W-1:0]   ch_sel;
    logic [WIN_W-1:0]  win_cycles;
    logic [NUM_CH-1:0] osc_in;
    logic [NUM_CH-1:0] osc_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              err;

    int  vectors     = 0;
    int  miscompares = 0;
    real osc_half [NUM_CH];

    ring_osc_freq_meter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W),
        .WIN_W(WIN_W), .CNT_W(CNT_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ch_sel(ch_sel), .win_cycles(win_cycles), .osc_in(osc_in),
        .osc_en(osc_en), .busy(busy), .done(done), .count(count),
        .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    // Free-running oscillator models; a half-period of 0 keeps the channel silent.
    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_osc
        logic osc_r;
        initial begin
            osc_r = 1'b0;
            forever begin
                if (osc_half[gi] > 0.0) begin
                    #(osc_half[gi]) osc_r = ~osc_r;
                end else begin
                    #5;
                end
            end
        end
        assign osc_in[gi] = osc_r;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected range %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Prescaled edges arrive every 2^DIV_W oscillator periods; each window boundary
    // may shift by one clk through the synchroniser.
    function automatic void model(input int ch, input int win, output int lo, output int hi);
        real h;
        real pm;
        real l;
        lo = 0;
        hi = 0;
        if (ch >= NUM_CH || win == 0) return;
        h = osc_half[ch];
        if (h <= 0.0) return;
        pm = 2.0 * h * real'(1 << DIV_W);
        l  = real'(win) * 10.0;
        lo = int'($floor((l - 20.0) / pm));
        if (lo < 0) lo = 0;
        hi = int'($floor((l + 20.0) / pm)) + 1;
    endfunction

    task automatic run_meas(input int ch, input int win, input bit spurious, input bit ab);
        int lo, hi, exp_lat, j, bad_en, seen_en, exp_ovf_chk;
        logic [NUM_CH-1:0] mask;
        bit short_path;
        logic [CNT_W-1:0] cnt_at_done;
        short_path = (ch >= NUM_CH) || (win == 0);
        exp_lat    = short_path ? 2 : SETTLE + win + 2;
        mask       = (ch >= NUM_CH) ? '0 : NUM_CH'(1) << ch;
        model(ch, win, lo, hi);
        ch_sel     = CH_W'(ch);
        win_cycles = WIN_W'(win);
        start      = 1'b1;
        abort      = ab;
        step();
        start   = 1'b0;
        abort   = 1'b0;
        j       = 1;
        bad_en  = 0;
        seen_en = 0;
        while (done !== 1'b1 && j < 400) begin
            if (!(osc_en == '0 || osc_en == mask)) bad_en++;
            if (busy && osc_en != mask) bad_en++;
            if (osc_en == mask && mask != '0) seen_en = 1;
            if (spurious && !short_path && j == 4) begin
                start      = 1'b1;
                ch_sel     = CH_W'((ch + 1) % NUM_CH);
                win_cycles = WIN_W'($urandom_range(1, 255));
            end
            step();
            start = 1'b0;
            j++;
        end
        chk("latency", j, exp_lat);
        chk("osc_en_lane", bad_en, 0);
        chk("osc_en_seen", seen_en, short_path ? 0 : 1);
        chk("osc_en_at_done", osc_en, 0);
        chk("busy_at_done", busy, 0);
        chk("err", err, (ch >= NUM_CH) ? 1 : 0);
        chk_rng("count", int'(count), (lo > CMAX) ? CMAX : lo, (hi > CMAX) ? CMAX : hi);
        exp_ovf_chk = 0;
        if (hi <= CMAX) begin
            chk("overflow", overflow, 0);
            exp_ovf_chk = 1;
        end else if (lo > CMAX) begin
            chk("overflow", overflow, 1);
            exp_ovf_chk = 1;
        end
        $display("meas ch=%0d win=%0d lat=%0d count=%0d ovf=%0d err=%0d model=%0d..%0d ovf_checked=%0d",
                 ch, win, j, count, overflow, err, lo, hi, exp_ovf_chk);
        cnt_at_done = count;
        step();
        chk("done_one_cycle", done, 0);
        chk("count_held", count, cnt_at_done);
    endtask

    initial begin
        int seen_done;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        ch_sel     = '0;
        win_cycles = '0;
        for (int i = 0; i < NUM_CH; i++) osc_half[i] = 0.0;
        step();
        step();
        chk("rst_osc_en", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Basic count: channel 3 at 20 ns period, 64-cycle window.
        osc_half[3] = 10.0;
        run_meas(3, 64, 1'b0, 1'b0);

        // Channel isolation: select 5 while only 7 runs.
        for (int i = 0; i < NUM_CH; i++) osc_half[i] = 0.0;
        osc_half[7] = 4.0;
        run_meas(5, 100, 1'b0, 1'b0);

        // Error and zero-window paths.
        run_meas(13, 50, 1'b0, 1'b0);
        osc_half[3] = 10.0;
        run_meas(3, 0, 1'b0, 1'b0);

        // Saturation, then recovery on a slow channel.
        osc_half[2] = 3.0;
        run_meas(2, 255, 1'b0, 1'b0);
        chk("sat_count", count, CMAX);
        chk("sat_overflow", overflow, 1);
        osc_half[9] = 40.0;
        run_meas(9, 100, 1'b0, 1'b0);

        // Ignored start during busy, and start winning over a simultaneous abort.
        run_meas(3, 40, 1'b1, 1'b1);

        // Abort in cycle 20 of MEASURE.
        ch_sel     = 4'd3;
        win_cycles = 8'd100;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (27) step();
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_osc_en", osc_en, 12'h008);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_osc_en", osc_en, 0);
        chk("abort_busy", busy, 0);
        seen_done = 0;
        for (int k = 0; k < 150; k++) begin
            if (done === 1'b1) seen_done++;
            step();
        end
        chk("abort_no_done", seen_done, 0);
        $display("abort ch=3 win=100 done_pulses=%0d", seen_done);

        // Asynchronous reset between clk edges in SETTLE.
        osc_half[2] = 15.0;
        ch_sel     = 4'd2;
        win_cycles = 8'd50;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("arst_pre_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_osc_en", osc_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_count", count, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_err", err, 0);
        $display("async reset applied mid-SETTLE");
        step();
        rst = 1'b0;
        step();
        run_meas(2, 50, 1'b0, 1'b0);

        // Randomized measurements against the period model.
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                osc_half[i] = ($urandom_range(0, 5) == 0) ? 0.0 : real'($urandom_range(3, 40));
            end
            repeat (3) step();
            run_meas(int'($urandom_range(0, 13)), int'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
- Parametrised on-chip frequency meter for a bank of NUM_CH ring-oscillator channels (gate style × fanout variants).
- Enables exactly one channel at a time and lets it settle.
- Counts prescaled oscillator edges over a programmable window of clk cycles, then reports the count with a start/done handshake.
- Sits between the ring-oscillator instances and the chip-level readout logic; it replaces direct pin observation of the oscillator outputs.

Parameters:
- NUM_CH, 12, number of oscillator channels; osc_in/osc_en width.
- CH_W, 4, width of ch_sel; must satisfy 2^CH_W >= NUM_CH.
- DIV_W, 4, prescaler depth; each channel's edges are divided by 2^DIV_W in the oscillator domain.
- WIN_W, 8, width of the measurement-window length, in clk cycles.
- CNT_W, 16, width of the result counter.
- SETTLE, 8, clk cycles the oscillator runs before counting starts.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  cancels a measurement in progress.
- ch_sel  input  CH_W  channel to measure.
- win_cycles  input  WIN_W  measurement window length.
- osc_in  input  NUM_CH  raw oscillator outputs, asynchronous to clk.
- osc_en  output  NUM_CH  one-hot oscillator enables.
- busy  output  1  high in SETTLE and MEASURE.
- done  output  1  one-cycle pulse when a result is valid.
- count  output  CNT_W  result; held until the next accepted start.
- overflow  output  1  count saturated during the last measurement.
- err  output  1  last request had ch_sel >= NUM_CH.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - osc_en=0, busy=0, done=0, count=0, overflow=0, err=0.
  - Prescaler and synchroniser flops clear.
- Prescaler:
  - DIV_W-bit up-counter clocked by the selected osc_in.
  - Cleared asynchronously by rst, and whenever osc_en is low.
  - Its MSB passes through a 2-flop synchroniser into clk, then a rising-edge detector.
  - Valid range: f_osc / 2^DIV_W < f_clk / 2.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - On start=1, latch ch_sel and win_cycles, clear count, overflow and err.
  - ch_sel >= NUM_CH: set err=1 and go to DONE; no oscillator is enabled.
  - win_cycles = 0: go to DONE with count=0.
  - Otherwise: assert osc_en[ch_sel] and go to SETTLE.
- SETTLE:
  - Runs SETTLE cycles with a cycle counter, then goes to MEASURE.
  - Edges are not counted in this state.
- MEASURE:
  - Runs exactly win_cycles clk cycles.
  - Each detected edge increments count.
  - At all-ones, count saturates and overflow is set; overflow is sticky until the next accepted start.
  - An edge detected in the last window cycle is counted.
- DONE:
  - done=1 for exactly one cycle.
  - osc_en=0 from the DONE cycle onward.
  - Next state is IDLE.
- Latency: accepted start to done = 1 + SETTLE + win_cycles cycles (+1 for the DONE cycle register).
  - Error path and zero-window path: done 2 cycles after start.
- busy is high in SETTLE and MEASURE only.
- start while not in IDLE is ignored; the latched ch_sel and win_cycles are unaffected.
- abort=1 in SETTLE or MEASURE:
  - Next state is IDLE, osc_en=0, no done pulse.
  - count holds its partial value and is not valid.
- abort in IDLE or DONE has no effect.
- If abort and start arrive together in IDLE, start wins.
- osc_en is one-hot or zero at all times; it never enables two channels.
- Reset mid-measurement: immediate return to the reset values, and the prescaler clears.

Test Plan:
- Basic count:
  - Stimulus: DIV_W=2, clk 10 ns, channel 3 bench model toggling at 20 ns period, win_cycles=64.
  - Required: osc_en=0x008 while busy; done after 1+8+64 cycles; count=8 ±1, overflow=0, err=0.
- Channel isolation:
  - Stimulus: ch_sel=5, only channel 7 toggling.
  - Required: count=0 and osc_en only ever 0x020.
- Error and zero-window paths:
  - Stimulus: ch_sel=13 with NUM_CH=12.
  - Required: err=1, count=0, osc_en never asserted, done 2 cycles after start.
  - Stimulus: win_cycles=0.
  - Required: count=0, done 2 cycles after start.
- Saturation:
  - Stimulus: CNT_W=4, fast oscillator, win_cycles=255.
  - Required: count=15, overflow=1.
  - Stimulus: next start with a slow channel.
  - Required: overflow clears and a valid count is reported.
- Abort and ignored start:
  - Stimulus: abort in cycle 20 of MEASURE.
  - Required: no done, osc_en=0 next cycle, busy=0.
  - Stimulus: start pulses during busy.
  - Required: no effect on the latched window or channel.
- Asynchronous reset:
  - Stimulus: rst pulse mid-SETTLE, between clk edges.
  - Required: all outputs 0 immediately; the next start measures normally.
